// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared constants, receiver state encoding and the
//               majority-of-three helper for the UART receive path.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    // Receiver state encoding
    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_start = 2'd1;
    localparam logic [1:0] c_st_data  = 2'd2;
    localparam logic [1:0] c_st_stop  = 2'd3;

    // Default frame geometry: baud ticks per bit and data bits per frame
    localparam int c_oversample_def = 8;
    localparam int c_data_bits_def  = 8;

    // Majority of three samples; a single corrupted sample cannot flip the bit
    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_sync.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_sync
// Description : Two-flop synchronisers for the serial line and the
//               oversampled baud clock, plus a rising-edge detector that
//               turns the baud clock into a one-cycle tick strobe.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_sync #(
    parameter logic RXD_RST_VAL  = 1'b1,
    parameter logic BAUD_RST_VAL = 1'b1,
    parameter logic HIST_RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic i_rxd,
    input  logic i_baud,
    output logic o_rxs,
    output logic o_tick
);

    logic [1:0] r_rxd_sync;
    logic [1:0] r_baud_sync;
    logic       r_baud_hist;

    // Capture both asynchronous inputs through two stages; keep one stage of baud history
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rxd_sync  <= {2{RXD_RST_VAL}};
            r_baud_sync <= {2{BAUD_RST_VAL}};
            r_baud_hist <= HIST_RST_VAL;
        end else begin
            r_rxd_sync  <= {r_rxd_sync[0], i_rxd};
            r_baud_sync <= {r_baud_sync[0], i_baud};
            r_baud_hist <= r_baud_sync[1];
        end
    end

    assign o_rxs  = r_rxd_sync[1];
    assign o_tick = r_baud_sync[1] & ~r_baud_hist;

endmodule
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx
// Description : 8N1 UART receiver. Detects the start bit, majority-votes
//               each bit around mid-bit, checks the stop bit and presents
//               the byte on a valid/ack holding register with frame-error
//               and overrun flags. All timing advances on baud ticks.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = c_oversample_def,
    parameter int DATA_BITS  = c_data_bits_def
) (
    input  logic                 sysClk,
    input  logic                 rst,
    input  logic                 baudClk,
    input  logic                 rxd,
    input  logic                 rxAck,
    output logic [DATA_BITS-1:0] rxData,
    output logic                 rxValid,
    output logic                 frameErr,
    output logic                 overrun,
    output logic                 rxBusy
);

    localparam int c_half   = OVERSAMPLE / 2;
    localparam int c_tcnt_w = $clog2(OVERSAMPLE);
    localparam int c_bcnt_w = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    // Sample points straddle mid-bit; the vote is taken on the last one
    localparam logic [c_tcnt_w-1:0] c_samp_lo   = c_tcnt_w'(c_half - 1);
    localparam logic [c_tcnt_w-1:0] c_samp_mid  = c_tcnt_w'(c_half);
    localparam logic [c_tcnt_w-1:0] c_samp_hi   = c_tcnt_w'(c_half + 1);
    localparam logic [c_tcnt_w-1:0] c_tcnt_last = c_tcnt_w'(OVERSAMPLE - 1);
    localparam logic [c_tcnt_w-1:0] c_tcnt_one  = c_tcnt_w'(1);
    localparam logic [c_bcnt_w-1:0] c_bcnt_last = c_bcnt_w'(DATA_BITS - 1);
    localparam logic [c_bcnt_w-1:0] c_bcnt_one  = c_bcnt_w'(1);

    logic w_rxs;
    logic w_tick;

    uart_rx_sync #(
        .RXD_RST_VAL  (1'b1),
        .BAUD_RST_VAL (1'b1),
        .HIST_RST_VAL (1'b0)
    ) u_sync (
        .clk    (sysClk),
        .rst    (rst),
        .i_rxd  (rxd),
        .i_baud (baudClk),
        .o_rxs  (w_rxs),
        .o_tick (w_tick)
    );

    logic [1:0]           r_state;
    logic [c_tcnt_w-1:0]  r_tcnt;
    logic [c_bcnt_w-1:0]  r_bcnt;
    logic [DATA_BITS-1:0] r_shreg;
    logic [1:0]           r_samp;
    logic                 r_armed;

    logic [1:0]           w_state_nxt;
    logic [c_tcnt_w-1:0]  w_tcnt_nxt;
    logic [c_bcnt_w-1:0]  w_bcnt_nxt;
    logic [DATA_BITS-1:0] w_shreg_nxt;
    logic [1:0]           w_samp_nxt;
    logic                 w_armed_nxt;
    logic                 w_frame_done;

    logic [DATA_BITS-1:0] r_rx_data;
    logic                 r_rx_valid;
    logic                 r_frame_err;
    logic                 r_overrun;

    // Vote uses the two stored samples plus the live third one
    logic w_vote;
    logic w_decide;
    logic w_wrap;
    assign w_vote   = maj3(r_samp[1], r_samp[0], w_rxs);
    assign w_decide = (r_tcnt == c_samp_hi);
    assign w_wrap   = (r_tcnt == c_tcnt_last);

    // Next-state logic for the bit-timing FSM; nothing moves except on a tick
    always_comb begin
        w_state_nxt  = r_state;
        w_tcnt_nxt   = r_tcnt;
        w_bcnt_nxt   = r_bcnt;
        w_shreg_nxt  = r_shreg;
        w_samp_nxt   = r_samp;
        w_armed_nxt  = r_armed;
        w_frame_done = 1'b0;

        if (w_tick) begin
            if (r_state == c_st_idle) begin
                // A start needs the line to have been seen high first, so a
                // held-low break yields one frame rather than a stream
                if (w_rxs) begin
                    w_armed_nxt = 1'b1;
                end else if (r_armed) begin
                    w_armed_nxt = 1'b0;
                    w_tcnt_nxt  = c_tcnt_one;
                    w_state_nxt = c_st_start;
                end
            end else begin
                w_tcnt_nxt = w_wrap ? '0 : (r_tcnt + c_tcnt_one);
                if (r_tcnt == c_samp_lo) begin
                    w_samp_nxt[1] = w_rxs;
                end
                if (r_tcnt == c_samp_mid) begin
                    w_samp_nxt[0] = w_rxs;
                end

                case (r_state)
                    c_st_start: begin
                        if (w_decide && w_vote) begin
                            // Line came back high: treat as a glitch
                            w_state_nxt = c_st_idle;
                            w_tcnt_nxt  = '0;
                        end else if (w_wrap) begin
                            w_state_nxt = c_st_data;
                            w_bcnt_nxt  = '0;
                        end
                    end
                    c_st_data: begin
                        if (w_decide) begin
                            w_shreg_nxt[r_bcnt] = w_vote;
                        end
                        if (w_wrap) begin
                            if (r_bcnt == c_bcnt_last) begin
                                w_state_nxt = c_st_stop;
                            end else begin
                                w_bcnt_nxt = r_bcnt + c_bcnt_one;
                            end
                        end
                    end
                    c_st_stop: begin
                        // Finish at mid stop bit so the next start edge is never missed
                        if (w_decide) begin
                            w_frame_done = 1'b1;
                            w_state_nxt  = c_st_idle;
                            w_tcnt_nxt   = '0;
                        end
                    end
                    default: begin
                        w_state_nxt = c_st_idle;
                    end
                endcase
            end
        end
    end

    // Bit-timing FSM registers
    always_ff @(posedge sysClk) begin
        if (rst) begin
            r_state <= c_st_idle;
            r_tcnt  <= '0;
            r_bcnt  <= '0;
            r_shreg <= '0;
            r_samp  <= '0;
            r_armed <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_tcnt  <= w_tcnt_nxt;
            r_bcnt  <= w_bcnt_nxt;
            r_shreg <= w_shreg_nxt;
            r_samp  <= w_samp_nxt;
            r_armed <= w_armed_nxt;
        end
    end

    // Host holding register: a completing frame takes priority over an ack
    always_ff @(posedge sysClk) begin
        if (rst) begin
            r_rx_data   <= '0;
            r_rx_valid  <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else if (w_frame_done) begin
            r_rx_data   <= r_shreg;
            r_rx_valid  <= 1'b1;
            r_frame_err <= ~w_vote;
            r_overrun   <= r_rx_valid & ~rxAck;
        end else if (rxAck && r_rx_valid) begin
            r_rx_valid  <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end
    end

    assign rxData   = r_rx_data;
    assign rxValid  = r_rx_valid;
    assign frameErr = r_frame_err;
    assign overrun  = r_overrun;
    assign rxBusy   = (r_state != c_st_idle);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx
// Description : Directed self-checking bench for uart_rx. A frame-level
//               model predicts the holding register from the bytes sent.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx;

    localparam int OS = 8;
    localparam int DB = 8;

    logic          sysClk  = 1'b0;
    logic          rst     = 1'b1;
    logic          baudClk = 1'b0;
    logic          rxd     = 1'b1;
    logic          rxAck   = 1'b0;
    logic [DB-1:0] rxData;
    logic          rxValid;
    logic          frameErr;
    logic          overrun;
    logic          rxBusy;

    uart_rx #(.OVERSAMPLE(OS), .DATA_BITS(DB)) dut (
        .sysClk   (sysClk),
        .rst      (rst),
        .baudClk  (baudClk),
        .rxd      (rxd),
        .rxAck    (rxAck),
        .rxData   (rxData),
        .rxValid  (rxValid),
        .frameErr (frameErr),
        .overrun  (overrun),
        .rxBusy   (rxBusy)
    );

    always #5 sysClk = ~sysClk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    int ack_at   = -1;
    bit chk_en   = 1'b0;

    typedef struct {
        int           at;
        logic [DB-1:0] d;
        logic         fe;
    } cmpl_t;
    cmpl_t pend[$];

    logic [DB-1:0] e_data  = '0;
    logic          e_valid = 1'b0;
    logic          e_ferr  = 1'b0;
    logic          e_ovr   = 1'b0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    // Baud clock: one rising edge every 4 sysClk
    initial forever begin
        repeat (2) @(posedge sysClk);
        #1 baudClk = ~baudClk;
    end

    // Ack driver: rxAck is high for exactly the sysClk edge numbered ack_at
    initial forever begin
        @(posedge sysClk);
        #1 rxAck = (cyc + 1 == ack_at);
    end

    // Frame-level model: a frame lands 3 sysClk after its stop-bit decision tick
    always @(posedge sysClk) begin
        cmpl_t c;
        cyc = cyc + 1;
        if (rst) begin
            e_data = '0; e_valid = 1'b0; e_ferr = 1'b0; e_ovr = 1'b0;
        end else if (pend.size() > 0 && pend[0].at == cyc) begin
            c = pend.pop_front();
            if (rxAck && e_valid) e_ovr = 1'b0;
            if (e_valid && !rxAck) e_ovr = 1'b1;
            e_valid = 1'b1;
            e_data  = c.d;
            e_ferr  = c.fe;
        end else if (rxAck && e_valid) begin
            e_valid = 1'b0; e_ferr = 1'b0; e_ovr = 1'b0;
        end
    end

    // Cycle-by-cycle comparison against the model
    always @(negedge sysClk) begin
        if (chk_en) begin
            check("rxValid",  {31'd0, rxValid},  {31'd0, e_valid});
            check("rxData",   {24'd0, rxData},   {24'd0, e_data});
            check("frameErr", {31'd0, frameErr}, {31'd0, e_ferr});
            check("overrun",  {31'd0, overrun},  {31'd0, e_ovr});
        end
    end

    // One bit period: 8 baud edges, optionally inverting the line on one of them
    task automatic hold_bit(input logic v, input int glitch_at);
        for (int j = 0; j < OS; j++) begin
            @(posedge baudClk);
            rxd = (j == glitch_at) ? ~v : v;
        end
    endtask

    task automatic idle_bits(input int n);
        for (int i = 0; i < n; i++) hold_bit(1'b1, -1);
    endtask

    task automatic send_frame(input logic [DB-1:0] d, input logic stop,
                              input int glitch_bit, input bit race_ack);
        hold_bit(1'b0, -1);
        for (int i = 0; i < DB; i++) begin
            if (i == 4) check("busy_mid", {31'd0, rxBusy}, 32'd1);
            hold_bit(d[i], (i == glitch_bit) ? OS / 2 : -1);
        end
        for (int j = 0; j < OS; j++) begin
            @(posedge baudClk);
            rxd = stop;
            if (j == OS / 2 + 1) begin
                pend.push_back('{at: cyc + 3, d: d, fe: ~stop});
                if (race_ack) ack_at = cyc + 3;
            end
        end
    endtask

    task automatic do_ack();
        ack_at = cyc + 2;
        repeat (2) @(posedge sysClk);
        @(negedge sysClk);
        check("ack_clears", {31'd0, rxValid}, 32'd0);
    endtask

    task automatic expect_hold(input string nm, input logic [DB-1:0] d,
                               input logic v, input logic fe, input logic ov);
        @(negedge sysClk);
        check({nm, "_data"},  {24'd0, rxData},   {24'd0, d});
        check({nm, "_valid"}, {31'd0, rxValid},  {31'd0, v});
        check({nm, "_ferr"},  {31'd0, frameErr}, {31'd0, fe});
        check({nm, "_ovr"},   {31'd0, overrun},  {31'd0, ov});
        check({nm, "_busy"},  {31'd0, rxBusy},   32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: run did not complete at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset
        @(posedge sysClk); #1;
        chk_en = 1'b1;
        repeat (3) @(posedge sysClk);
        #1 rst = 1'b0;
        expect_hold("reset", 8'h00, 1'b0, 1'b0, 1'b0);

        // Clean byte
        idle_bits(2);
        send_frame(8'hA5, 1'b1, -1, 1'b0);
        idle_bits(1);
        expect_hold("clean", 8'hA5, 1'b1, 1'b0, 1'b0);
        do_ack();

        // False start: two low ticks then high
        @(posedge baudClk); rxd = 1'b0;
        @(posedge baudClk); rxd = 1'b0;
        @(posedge baudClk); rxd = 1'b1;
        check("false_busy", {31'd0, rxBusy}, 32'd1);
        idle_bits(2);
        check("false_idle",  {31'd0, rxBusy},  32'd0);
        check("false_valid", {31'd0, rxValid}, 32'd0);

        // Single-tick glitch at mid-bit of data bit 3
        send_frame(8'h00, 1'b1, 3, 1'b0);
        idle_bits(1);
        expect_hold("glitch", 8'h00, 1'b1, 1'b0, 1'b0);
        do_ack();

        // Low stop bit
        send_frame(8'h3C, 1'b0, -1, 1'b0);
        idle_bits(2);
        expect_hold("framing", 8'h3C, 1'b1, 1'b1, 1'b0);
        do_ack();

        // Break: line low for 20 bit times gives exactly one frame
        for (int j = 0; j < 20 * OS; j++) begin
            @(posedge baudClk);
            rxd = 1'b0;
            if (j == 9 * OS + OS / 2 + 1) pend.push_back('{at: cyc + 3, d: 8'h00, fe: 1'b1});
        end
        idle_bits(2);
        expect_hold("break", 8'h00, 1'b1, 1'b1, 1'b0);
        do_ack();

        // Overrun: two frames without ack
        send_frame(8'h11, 1'b1, -1, 1'b0);
        send_frame(8'h22, 1'b1, -1, 1'b0);
        idle_bits(1);
        expect_hold("overrun", 8'h22, 1'b1, 1'b0, 1'b1);
        do_ack();

        // Ack coincident with completion of the second frame
        send_frame(8'h11, 1'b1, -1, 1'b0);
        send_frame(8'h22, 1'b1, -1, 1'b1);
        idle_bits(1);
        expect_hold("race", 8'h22, 1'b1, 1'b0, 1'b0);

        // Reset during data bit 5 of 0x5A, holding register still full
        hold_bit(1'b0, -1);
        for (int i = 0; i < 5; i++) hold_bit(1'(8'h5A >> i), -1);
        @(posedge baudClk); rxd = 1'b0;
        repeat (3) @(posedge baudClk);
        @(posedge sysClk);
        #1 rst = 1'b1; rxd = 1'b1;
        repeat (2) @(posedge sysClk);
        #1 rst = 1'b0;
        expect_hold("mid_reset", 8'h00, 1'b0, 1'b0, 1'b0);
        idle_bits(2);
        send_frame(8'h81, 1'b1, -1, 1'b0);
        idle_bits(1);
        expect_hold("after_reset", 8'h81, 1'b1, 1'b0, 1'b0);
        do_ack();

        if (pend.size() != 0) begin
            n_errors++;
            $display("FAIL pending_frames: got %0d expected 0", pend.size());
        end
        n_checks++;

        repeat (4) @(posedge sysClk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
